// File: rtl/dpi_pkg.sv
// Shared types for the DPI stream sequencer: stream-ID width, table depth,
// regex count, FSM state encoding and the per-packet result record.
package dpi_pkg;

   localparam int SID_W       = 6;
   localparam int NUM_STREAMS = 64;
   localparam int NUM_RE      = 8;
   localparam int CHAR_W      = 8;

   typedef logic [SID_W-1:0]  sid_t;
   typedef logic [NUM_RE-1:0] re_mask_t;
   typedef logic [CHAR_W-1:0] char_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_PRIME  = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_EOP    = 3'd5,
      ST_REPORT = 3'd6
   } state_e;

   typedef struct packed {
      sid_t     sid;
      re_mask_t match;
   } result_t;

endpackage

// File: rtl/dpi_stream_sequencer_if.sv
// Bundle of the packet input, config, matcher-control and result signals.
// The sequencer uses the slave view; the environment drives the master view.
interface dpi_stream_sequencer_if;
   import dpi_pkg::*;

   logic     in_valid;
   logic     in_ready;
   char_t    in_data;
   logic     in_sop;
   logic     in_eop;
   sid_t     in_sid;

   logic     cfg_we;
   sid_t     cfg_sid;
   re_mask_t cfg_mask;
   logic     cfg_clear;

   logic     re_load_state;
   logic     re_new_stream_id;
   logic     re_eop;
   sid_t     re_stream_id;
   char_t    re_char;
   logic     re_char_vld;
   re_mask_t re_enable;
   re_mask_t re_fired;

   logic     res_valid;
   sid_t     res_sid;
   re_mask_t res_match;
   logic     err;
   logic     busy;

   modport master (
      output in_valid, in_data, in_sop, in_eop, in_sid,
      output cfg_we, cfg_sid, cfg_mask, cfg_clear,
      output re_fired,
      input  in_ready,
      input  re_load_state, re_new_stream_id, re_eop, re_stream_id,
      input  re_char, re_char_vld, re_enable,
      input  res_valid, res_sid, res_match, err, busy
   );

   modport slave (
      input  in_valid, in_data, in_sop, in_eop, in_sid,
      input  cfg_we, cfg_sid, cfg_mask, cfg_clear,
      input  re_fired,
      output in_ready,
      output re_load_state, re_new_stream_id, re_eop, re_stream_id,
      output re_char, re_char_vld, re_enable,
      output res_valid, res_sid, res_match, err, busy
   );

endinterface

// File: rtl/dpi_stream_table.sv
// Per-stream state: one "seen" bit and one regex enable mask per stream ID,
// with a combinational read port, a config write port, set-seen and clear.
module dpi_stream_table
   import dpi_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  sid_t     i_rd_sid,
   output logic     o_rd_seen,
   output re_mask_t o_rd_mask,
   input  logic     i_cfg_we,
   input  sid_t     i_cfg_sid,
   input  re_mask_t i_cfg_mask,
   input  logic     i_set_seen,
   input  sid_t     i_set_sid,
   input  logic     i_clear
);

   logic [NUM_STREAMS-1:0] r_seen;
   logic [NUM_STREAMS-1:0] w_seen_nxt;
   re_mask_t               r_mask [NUM_STREAMS];

   // Clear is applied before the set so a packet ending on the clear cycle
   // is still remembered.
   always_comb begin
      // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
      w_seen_nxt = i_clear ? '0 : r_seen;
      if (i_set_seen) begin
         w_seen_nxt[i_set_sid] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
      if (!rst_n) begin
         r_seen <= '0;
      end else begin
         r_seen <= w_seen_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the mask file is a flop array that must read as all-zero after
      // reset, so every entry is reset explicitly (no RAM macro here).
      if (!rst_n) begin
         for (int i = 0; i < NUM_STREAMS; i++) begin
            r_mask[i] <= '0;
         end
      end else if (i_cfg_we) begin
         r_mask[i_cfg_sid] <= i_cfg_mask;
      end
   end

   assign o_rd_seen = r_seen[i_rd_sid];
   assign o_rd_mask = r_mask[i_rd_sid];

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Front-end controller for the regex matcher bank: sequences load/prime,
// streams packet bytes, drains, signals end-of-packet and reports matches.
module dpi_stream_sequencer
   import dpi_pkg::*;
#(
   parameter int DRAIN_CYC = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   dpi_stream_sequencer_if.slave bus
);

   localparam int              CNT_W      = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC);

   state_e           r_state;
   state_e           w_state_nxt;
   sid_t             r_sid;
   re_mask_t         r_enable;
   char_t            r_char;
   logic             r_char_vld;
   logic [CNT_W-1:0] r_drain_cnt;
   logic             r_first;
   result_t          r_res;
   logic             r_err;

   logic     w_idle_sop;
   logic     w_idle_drop;
   logic     w_in_ready;
   logic     w_accept;
   logic     w_stream_acc;
   logic     w_proto_err;
   logic     w_seen;
   re_mask_t w_mask;

   // The sop beat is only observed in IDLE; it is consumed later in STREAM.
   assign w_idle_sop   = (r_state == ST_IDLE) & bus.in_valid & bus.in_sop;
   assign w_idle_drop  = (r_state == ST_IDLE) & bus.in_valid & ~bus.in_sop;
   assign w_in_ready   = (r_state == ST_STREAM) | w_idle_drop;
   assign w_accept     = bus.in_valid & w_in_ready;
   assign w_stream_acc = (r_state == ST_STREAM) & w_accept;
   assign w_proto_err  = w_idle_drop | (w_stream_acc & bus.in_sop & ~r_first);

   dpi_stream_table u_table (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd_sid   (r_sid),
      .o_rd_seen  (w_seen),
      .o_rd_mask  (w_mask),
      .i_cfg_we   (bus.cfg_we),
      .i_cfg_sid  (bus.cfg_sid),
      .i_cfg_mask (bus.cfg_mask),
      .i_set_seen (r_state == ST_EOP),
      .i_set_sid  (r_sid),
      .i_clear    (bus.cfg_clear)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_idle_sop) w_state_nxt = ST_LOAD;
         ST_LOAD:   w_state_nxt = ST_PRIME;
         ST_PRIME:  w_state_nxt = ST_STREAM;
         ST_STREAM: if (w_stream_acc && bus.in_eop) w_state_nxt = ST_DRAIN;
         ST_DRAIN:  if (r_drain_cnt == DRAIN_LAST) w_state_nxt = ST_EOP;
         ST_EOP:    w_state_nxt = ST_REPORT;
         ST_REPORT: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_sid   <= '0;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_idle_sop) begin
            r_sid <= bus.in_sid;
         end
         if (r_state == ST_PRIME) begin
            r_first <= 1'b1;
         end else if (w_stream_acc) begin
            r_first <= 1'b0;
         end
      end
   end

   // Drain count 0 is the cycle the last character is on the bus; counts
   // 1..DRAIN_CYC are the idle cycles before re_eop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_char      <= '0;
         r_char_vld  <= 1'b0;
         r_drain_cnt <= '0;
      end else begin
         r_char_vld <= w_stream_acc;
         if (w_stream_acc) begin
            r_char <= bus.in_data;
         end
         if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + CNT_W'(1);
         end else begin
            r_drain_cnt <= '0;
         end
      end
   end

   // The enable mask is frozen at LOAD so mid-packet config writes only
   // affect the stream's next packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enable <= '0;
         r_res    <= '0;
         r_err    <= 1'b0;
      end else begin
         if (r_state == ST_LOAD) begin
            r_enable <= w_mask;
         end
         if (r_state == ST_EOP) begin
            r_res <= '{sid: r_sid, match: bus.re_fired & r_enable};
         end
         if (w_proto_err) begin
            r_err <= 1'b1;
         end else if (bus.cfg_clear) begin
            r_err <= 1'b0;
         end
      end
   end

   assign bus.in_ready         = w_in_ready;
   assign bus.re_load_state    = (r_state == ST_LOAD);
   assign bus.re_new_stream_id = (r_state == ST_LOAD) & ~w_seen;
   assign bus.re_eop           = (r_state == ST_EOP);
   assign bus.re_stream_id     = r_sid;
   assign bus.re_char          = r_char;
   assign bus.re_char_vld      = r_char_vld;
   assign bus.re_enable        = r_enable;
   assign bus.res_valid        = (r_state == ST_REPORT);
   assign bus.res_sid          = r_res.sid;
   assign bus.res_match        = r_res.match;
   assign bus.err              = r_err;
   assign bus.busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: a packet-level model predicts
// matcher-bus events and results; a monitor compares them every cycle.
module tb_dpi_stream_sequencer;
   import dpi_pkg::*;

   localparam int DRAIN_CYC = 2;

   typedef struct {
      logic [5:0] sid;
      logic       is_new;
      logic [7:0] enable;
      logic [7:0] match;
   } pkt_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dpi_stream_sequencer_if bus ();

   dpi_stream_sequencer #(.DRAIN_CYC(DRAIN_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Packet-level model state.
   logic       m_seen [64];
   logic [7:0] m_mask [64];
   logic [7:0] fired_val;
   pkt_t       exp_q [$];
   logic [7:0] chr_q [$];

   int         sop_cyc;
   int         acc_cyc;
   logic       first_pending = 1'b0;
   int         n_load = 0;
   int         n_char = 0;
   int         n_res  = 0;
   logic       last_new;
   logic [5:0] last_res_sid;
   logic [7:0] last_res_match;
   pkt_t       mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every cycle out of reset, compare bus events with the model.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.re_load_state) begin
            n_load++;
            last_new = bus.re_new_stream_id;
            if (exp_q.size() == 0) check("load_unexpected", 1, 0);
            else begin
               check("load_sid", bus.re_stream_id, exp_q[0].sid);
               check("new_stream_id", bus.re_new_stream_id, exp_q[0].is_new);
            end
         end
         if (bus.re_char_vld) begin
            n_char++;
            if (chr_q.size() == 0) check("char_unexpected", 1, 0);
            else check("char", bus.re_char, chr_q.pop_front());
            if (first_pending) begin
               check("sop_to_char_latency", cyc - sop_cyc, 4);
               first_pending = 1'b0;
            end
         end
         if (bus.re_eop) begin
            check("eop_latency", cyc - acc_cyc, DRAIN_CYC + 2);
            if (exp_q.size() == 0) check("eop_unexpected", 1, 0);
            else check("eop_enable", bus.re_enable, exp_q[0].enable);
         end
         if (bus.res_valid) begin
            n_res++;
            last_res_sid   = bus.res_sid;
            last_res_match = bus.res_match;
            if (exp_q.size() == 0) check("res_unexpected", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               check("res_sid", bus.res_sid, mon_e.sid);
               check("res_match", bus.res_match, mon_e.match);
            end
         end
      end
   end

   task automatic init_inputs();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_sop    = 1'b0;
      bus.in_eop    = 1'b0;
      bus.in_sid    = '0;
      bus.cfg_we    = 1'b0;
      bus.cfg_sid   = '0;
      bus.cfg_mask  = '0;
      bus.cfg_clear = 1'b0;
      bus.re_fired  = '0;
      for (int i = 0; i < 64; i++) begin
         m_seen[i] = 1'b0;
         m_mask[i] = 8'h00;
      end
      fired_val = 8'h00;
   endtask

   task automatic set_fired(input logic [7:0] f);
      fired_val    = f;
      bus.re_fired = f;
   endtask

   task automatic cfg_write(input logic [5:0] sid, input logic [7:0] mask);
      bus.cfg_we   = 1'b1;
      bus.cfg_sid  = sid;
      bus.cfg_mask = mask;
      m_mask[sid]  = mask;
      @(posedge clk); #1;
      bus.cfg_we   = 1'b0;
   endtask

   task automatic cfg_clear_pulse();
      bus.cfg_clear = 1'b1;
      for (int i = 0; i < 64; i++) m_seen[i] = 1'b0;
      @(posedge clk); #1;
      bus.cfg_clear = 1'b0;
   endtask

   // Present one beat from posedge+1 and hold it until accepted (bounded).
   task automatic drive_beat(input logic [7:0] d, input logic sop, input logic eop,
                             input logic [5:0] sid);
      bit done;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_sop   = sop;
      bus.in_eop   = eop;
      bus.in_sid   = sid;
      done = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            done    = 1'b1;
            acc_cyc = cyc;
         end
         @(posedge clk); #1;
      end
      if (!done) check("beat_accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
   endtask

   task automatic send_pkt(input logic [5:0] sid, input int len, input logic [63:0] data,
                           input logic [7:0] gaps, input int wr_at, input logic [7:0] wr_mask);
      pkt_t e;
      e.sid    = sid;
      e.is_new = !m_seen[sid];
      e.enable = m_mask[sid];
      e.match  = fired_val & m_mask[sid];
      exp_q.push_back(e);
      for (int i = 0; i < len; i++) chr_q.push_back(data[8*i +: 8]);
      m_seen[sid] = 1'b1;
      for (int i = 0; i < len; i++) begin
         if (gaps[i] && i != 0) begin
            @(posedge clk); #1;
         end
         if (i == 0) begin
            sop_cyc       = cyc;
            first_pending = 1'b1;
         end
         if (i == wr_at) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_sid  = sid;
            bus.cfg_mask = wr_mask;
            m_mask[sid]  = wr_mask;
         end
         drive_beat(data[8*i +: 8], i == 0, i == len - 1, (i == 0) ? sid : ~sid);
         bus.cfg_we = 1'b0;
      end
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      if (exp_q.size() != 0) check("result_timeout", exp_q.size(), 0);
   endtask

   initial begin
      int c0;
      int l0;
      int r0;
      init_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",     bus.in_ready, 0);
      check("rst_busy",         bus.busy, 0);
      check("rst_err",          bus.err, 0);
      check("rst_res_valid",    bus.res_valid, 0);
      check("rst_char_vld",     bus.re_char_vld, 0);
      check("rst_load_state",   bus.re_load_state, 0);
      check("rst_enable",       bus.re_enable, 0);
      check("rst_stream_id",    bus.re_stream_id, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First packet on a fresh stream.
      cfg_write(6'd5, 8'h03);
      set_fired(8'h01);
      send_pkt(6'd5, 4, 64'h44332211, 8'h00, -1, 8'h00);
      check("p1_new_literal",   last_new, 1);
      check("p1_sid_literal",   last_res_sid, 5);
      check("p1_match_literal", last_res_match, 8'h01);

      // Same stream again, with a one-cycle gap before beat 2.
      c0 = n_char;
      send_pkt(6'd5, 3, 64'h00c3b2a1, 8'b0000_0100, -1, 8'h00);
      check("p2_new_literal",   last_new, 0);
      check("p2_char_count",    n_char - c0, 3);

      // Single-byte packet: sop and eop on one beat.
      c0 = n_char;
      send_pkt(6'd9, 1, 64'h5a, 8'h00, -1, 8'h00);
      check("p3_char_count",    n_char - c0, 1);
      check("p3_match_literal", last_res_match, 8'h00);

      // Non-sop beat in IDLE is dropped and flags an error.
      l0 = n_load;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      bus.in_sop   = 1'b0;
      @(negedge clk);
      check("idle_drop_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("idle_drop_err", bus.err, 1);
      repeat (4) @(posedge clk);
      #1;
      check("idle_drop_no_load", n_load - l0, 0);
      check("idle_drop_busy",    bus.busy, 0);
      cfg_clear_pulse();
      check("clear_err",         bus.err, 0);
      send_pkt(6'd5, 2, 64'h0e0d, 8'h00, -1, 8'h00);
      check("clear_seen_new",    last_new, 1);

      // Mask write to the active stream applies from its next packet.
      cfg_write(6'd7, 8'hF0);
      set_fired(8'hFF);
      send_pkt(6'd7, 4, 64'h78675645, 8'h00, 2, 8'h0F);
      check("p7a_match_literal", last_res_match, 8'hF0);
      send_pkt(6'd7, 2, 64'h9a89, 8'h00, -1, 8'h00);
      check("p7b_match_literal", last_res_match, 8'h0F);

      // Reset in the middle of a packet abandons it.
      cfg_write(6'd3, 8'h3C);
      set_fired(8'hAA);
      begin
         pkt_t e;
         e.sid = 6'd3; e.is_new = 1'b1; e.enable = 8'h3C; e.match = 8'h28;
         exp_q.push_back(e);
      end
      chr_q.push_back(8'h71);
      chr_q.push_back(8'h72);
      r0 = n_res;
      sop_cyc       = cyc;
      first_pending = 1'b1;
      drive_beat(8'h71, 1'b1, 1'b0, 6'd3);
      drive_beat(8'h72, 1'b0, 1'b0, 6'd60);
      rst_n = 1'b0;
      #1;
      check("mid_rst_char_vld",  bus.re_char_vld, 0);
      check("mid_rst_in_ready",  bus.in_ready, 0);
      check("mid_rst_busy",      bus.busy, 0);
      check("mid_rst_stream_id", bus.re_stream_id, 0);
      check("mid_rst_enable",    bus.re_enable, 0);
      exp_q.delete();
      chr_q.delete();
      first_pending = 1'b0;
      for (int i = 0; i < 64; i++) begin
         m_seen[i] = 1'b0;
         m_mask[i] = 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("mid_rst_no_result", n_res - r0, 0);
      send_pkt(6'd3, 2, 64'h7473, 8'h00, -1, 8'h00);
      check("post_rst_new",   last_new, 1);
      check("post_rst_match", last_res_match, 8'h00);

      check("exp_q_drained", exp_q.size(), 0);
      check("chr_q_drained", chr_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
